// File: rtl/itree_pkg.sv
`default_nettype none
// ============================================================================
// itree_pkg : shared constants, FSM state encoding and score-width helper
//             for the isolation-forest scheduler.
// Revision  : 1.0
// ============================================================================
package itree_pkg;

    localparam int unsigned C_NUM_TREES   = 4;
    localparam int unsigned C_TREE_W      = 256;
    localparam int unsigned C_DATA_W      = 8;
    localparam int unsigned C_PLEN_W      = 4;
    localparam int unsigned C_WDOG_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    // Wide enough for NUM_TREES maximal path lengths, so the sum never wraps.
    function automatic int unsigned score_w(input int unsigned num_trees,
                                            input int unsigned plen_w);
        return plen_w + $clog2(num_trees);
    endfunction

endpackage
`default_nettype wire

// File: rtl/itree_bank.sv
`default_nettype none
// ============================================================================
// itree_bank : register array of serialized tree images, one write port and
//              one combinational read port, cleared on reset.
// Revision   : 1.0
// ============================================================================
module itree_bank #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] entry_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (we_i) begin
            entry_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = entry_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/forest_scheduler.sv
`default_nettype none
// ============================================================================
// forest_scheduler : time-shares one isolation-tree engine over NUM_TREES
//                    banked trees and sums path lengths into an anomaly score.
//                    Optional engine watchdog: FOREST_SCHEDULER_WDOG_EN
// Revision         : 1.0
// ============================================================================
module forest_scheduler
    import itree_pkg::*;
#(
    parameter  int unsigned NUM_TREES   = C_NUM_TREES,
    parameter  int unsigned TREE_W      = C_TREE_W,
    parameter  int unsigned DATA_W      = C_DATA_W,
    parameter  int unsigned PLEN_W      = C_PLEN_W,
    parameter  int unsigned WDOG_CYCLES = C_WDOG_CYCLES,
    localparam int unsigned IDX_W       = $clog2(NUM_TREES),
    localparam int unsigned SCORE_W     = score_w(NUM_TREES, PLEN_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [TREE_W-1:0]  cfg_tree,
    output logic               cfg_drop,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    output logic               eng_load,
    output logic [TREE_W-1:0]  eng_tree,
    output logic               eng_start,
    output logic [DATA_W-1:0]  eng_data,
    input  logic               eng_done,
    input  logic [PLEN_W-1:0]  eng_plen,
    input  logic [SCORE_W-1:0] thresh,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SCORE_W-1:0] res_score,
    output logic               res_anomaly,
    output logic               busy,
    output logic               wdog_err
);

    localparam int unsigned        WDOG_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [SCORE_W-1:0] PLEN_MAX = SCORE_W'((1 << PLEN_W) - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_TREES - 1);
    localparam logic [WDOG_W-1:0]  WDOG_TOP = WDOG_W'(WDOG_CYCLES - 1);
`ifdef FOREST_SCHEDULER_WDOG_EN
    localparam bit                 WDOG_EN  = 1'b1;
`else
    localparam bit                 WDOG_EN  = 1'b0;
`endif

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SCORE_W-1:0]  acc_q;
    logic [SCORE_W-1:0]  acc_d;
    logic [DATA_W-1:0]   sample_q;
    logic                eng_load_q;
    logic                eng_start_q;
    logic                res_valid_q;
    logic                res_anomaly_q;
    logic                cfg_drop_q;
    logic                wdog_err_q;
    logic [WDOG_W-1:0]   wdog_cnt_q;
    logic                wdog_fire;
    logic                bank_we;
    logic [TREE_W-1:0]   bank_rdata;

    // The bank only changes while idle, so LOAD always reads a settled image.
    assign bank_we   = cfg_we && (state_q == ST_IDLE);
    assign wdog_fire = WDOG_EN && (state_q == ST_WAIT) && !eng_done && (wdog_cnt_q == WDOG_TOP);
    assign acc_d     = acc_q + (wdog_fire ? PLEN_MAX : SCORE_W'(eng_plen));

    itree_bank #(
        .DEPTH (NUM_TREES),
        .WIDTH (TREE_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we),
        .waddr_i (cfg_idx),
        .wdata_i (cfg_tree),
        .raddr_i (idx_q),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            sample_q      <= '0;
            eng_load_q    <= 1'b0;
            eng_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_anomaly_q <= 1'b0;
            cfg_drop_q    <= 1'b0;
            wdog_err_q    <= 1'b0;
            wdog_cnt_q    <= '0;
        end else begin
            eng_load_q  <= 1'b0;
            eng_start_q <= 1'b0;
            cfg_drop_q  <= cfg_we && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        sample_q   <= s_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        eng_load_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    eng_start_q <= 1'b1;
                    state_q     <= ST_START;
                end
                ST_START: begin
                    wdog_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done || wdog_fire) begin
                        acc_q <= acc_d;
                        if (wdog_fire) begin
                            wdog_err_q <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            res_valid_q   <= 1'b1;
                            res_anomaly_q <= (acc_d < thresh);
                            state_q       <= ST_RESULT;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            eng_load_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end else if (WDOG_EN) begin
                        wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_anomaly_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready     = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign eng_load    = eng_load_q;
    assign eng_tree    = bank_rdata;
    assign eng_start   = eng_start_q;
    assign eng_data    = sample_q;
    assign res_valid   = res_valid_q;
    assign res_score   = acc_q;
    assign res_anomaly = res_anomaly_q;
    assign cfg_drop    = cfg_drop_q;
    assign wdog_err    = WDOG_EN ? wdog_err_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_forest_scheduler.sv
`default_nettype none
// ============================================================================
// tb_forest_scheduler : self-checking bench with a behavioural engine and
//                       score model for forest_scheduler.
// Revision            : 1.0
// ============================================================================
module tb_forest_scheduler;

    localparam int NT = 4;
    localparam int TW = 256;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int WD = 64;
    localparam int SW = 6;
    localparam int IW = 2;
`ifdef FOREST_SCHEDULER_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [TW-1:0] cfg_tree;
    logic          cfg_drop;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          eng_load;
    logic [TW-1:0] eng_tree;
    logic          eng_start;
    logic [DW-1:0] eng_data;
    logic          eng_done;
    logic [PW-1:0] eng_plen;
    logic [SW-1:0] thresh;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_score;
    logic          res_anomaly;
    logic          busy;
    logic          wdog_err;

    forest_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_tree    (cfg_tree),
        .cfg_drop    (cfg_drop),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .eng_load    (eng_load),
        .eng_tree    (eng_tree),
        .eng_start   (eng_start),
        .eng_data    (eng_data),
        .eng_done    (eng_done),
        .eng_plen    (eng_plen),
        .thresh      (thresh),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_score   (res_score),
        .res_anomaly (res_anomaly),
        .busy        (busy),
        .wdog_err    (wdog_err)
    );

    always #5 clk = ~clk;

    int            total;
    int            bad;
    int            drop_cnt = 0;
    logic [TW-1:0] mbank [NT];
    int            plen_v [NT];
    int            dly_v  [NT];
    bit            spurious;
    bit            cfg_in_wait;

    typedef struct {
        logic [DW-1:0]        smp;
        logic [SW-1:0]        th;
        logic [NT-1:0][PW-1:0] plen;
        logic [NT-1:0][3:0]   dly;
        logic [SW-1:0]        exp_score;
        logic                 exp_anom;
    } vec_t;

    vec_t vecs [7];

    always @(posedge clk) begin
        if (cfg_drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_tree(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_tree();
        logic [TW-1:0] r;
        for (int k = 0; k < TW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a silent tree (when the watchdog exists) counts as the
    // maximum path length after WD WAIT cycles.
    function automatic int model_score();
        int s = 0;
        for (int t = 0; t < NT; t++) begin
            if (WDOG_ON && dly_v[t] >= WD) s += (1 << PW) - 1;
            else s += plen_v[t];
        end
        return s;
    endfunction

    function automatic int model_latency();
        int l = 3 * NT + 1;
        for (int t = 0; t < NT; t++) begin
            if (WDOG_ON && dly_v[t] >= WD) l += WD - 1;
            else l += dly_v[t];
        end
        return l;
    endfunction

    task automatic do_reset();
        reset = 1'b0; s_valid = 1'b0; cfg_we = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < NT; t++) mbank[t] = '0;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int idx, input logic [TW-1:0] img);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_tree = img;
        @(negedge clk);
        cfg_we = 1'b0;
        mbank[idx] = img;
    endtask

    task automatic start_sample(input logic [DW-1:0] smp, input bit with_cfg,
                                input int idx, input logic [TW-1:0] img);
        chk("s_ready_idle", 64'(s_ready), 64'd1);
        s_valid = 1'b1; s_data = smp;
        if (with_cfg) begin cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_tree = img; end
        if (spurious) begin eng_done = 1'b1; eng_plen = '1; end
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0; eng_done = 1'b0;
        if (with_cfg) mbank[idx] = img;
    endtask

    // Behavioural engine: answers each start after dly_v[tree] extra cycles.
    task automatic run_engine(input logic [DW-1:0] smp, input int budget,
                              output bit got, output int cyc);
        int loads = 0, starts = 0, cnt = 0, tree = 0;
        bit pend = 0, cfg_sent = 0;
        got = 0; cyc = 1;
        while (cyc <= budget) begin
            eng_done = 1'b0; cfg_we = 1'b0;
            if (res_valid === 1'b1) begin got = 1; break; end
            if (eng_load === 1'b1) begin
                chk_tree("eng_tree", eng_tree, mbank[loads % NT]);
                loads++;
                if (spurious) begin eng_done = 1'b1; eng_plen = '1; end
            end
            if (eng_start === 1'b1) begin
                chk("eng_data", 64'(eng_data), 64'(smp));
                tree = starts % NT; cnt = dly_v[tree]; starts++; pend = 1;
            end else if (pend) begin
                if (cfg_in_wait && !cfg_sent) begin
                    cfg_we = 1'b1; cfg_idx = '0; cfg_tree = ~mbank[0]; cfg_sent = 1;
                end
                if (cnt == 0) begin
                    eng_done = 1'b1; eng_plen = PW'(plen_v[tree]); pend = 0;
                end else cnt--;
            end
            @(negedge clk);
            cyc++;
        end
        eng_done = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic finish_result(input logic [SW-1:0] exp_sc, input logic exp_an,
                                 input int hold, input bit offer, input logic [DW-1:0] nxt);
        bit stable = 1;
        chk("res_score", 64'(res_score), 64'(exp_sc));
        chk("res_anomaly", 64'(res_anomaly), 64'(exp_an));
        chk("result_busy", 64'({busy, s_ready}), 64'b10);
        res_ready = 1'b0;
        if (offer) begin s_valid = 1'b1; s_data = nxt; end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_score !== exp_sc || res_anomaly !== exp_an ||
                s_ready !== 1'b0 || busy !== 1'b1) stable = 0;
        end
        if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after_hs", 64'({res_valid, s_ready, busy}), 64'b010);
        if (offer) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic eval(input logic [DW-1:0] smp, input logic [SW-1:0] th,
                        input logic [SW-1:0] exp_sc, input logic exp_an, input bit accepted,
                        input int hold, input bit offer, input logic [DW-1:0] nxt);
        int lat, cyc;
        bit got;
        lat = model_latency();
        thresh = th;
        if (!accepted) start_sample(smp, 1'b0, 0, '0);
        run_engine(smp, 2000, got, cyc);
        chk("result_seen", 64'(got), 64'd1);
        if (got) begin
            chk("latency", 64'(cyc), 64'(lat));
            finish_result(exp_sc, exp_an, hold, offer, nxt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   cyc, d0, sc;
        bit   got;
        total = 0; bad = 0; spurious = 0; cfg_in_wait = 0;
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_tree = '0; s_valid = 1'b0;
        s_data = '0; eng_done = 1'b0; eng_plen = '0; thresh = '0; res_ready = 1'b0;
        for (int t = 0; t < NT; t++) mbank[t] = '0;

        vecs[0] = '{8'h5A, 6'd20, 16'h6543, 16'h0000, 6'd18, 1'b1};
        vecs[1] = '{8'h5A, 6'd18, 16'h6543, 16'h0000, 6'd18, 1'b0};
        vecs[2] = '{8'hFF, 6'd63, 16'hFFFF, 16'h0201, 6'd60, 1'b1};
        vecs[3] = '{8'h00, 6'd0,  16'h0000, 16'h0000, 6'd0,  1'b0};
        vecs[4] = '{8'h3C, 6'd10, 16'h7021, 16'h3333, 6'd10, 1'b0};
        vecs[5] = '{8'hA5, 6'd37, 16'h9999, 16'h1000, 6'd36, 1'b1};
        vecs[6] = '{8'h81, 6'd1,  16'h0100, 16'h0000, 6'd1,  1'b0};

        // Reset state, both while held and after release.
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({s_ready, busy, res_valid, eng_load, eng_start, cfg_drop, wdog_err}), 64'b1000000);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ctrl", 64'({s_ready, busy, res_valid, eng_load, eng_start, cfg_drop, wdog_err}), 64'b1000000);
        chk("rel_score", 64'(res_score), 64'd0);
        chk_tree("rel_tree", eng_tree, '0);

        for (int t = 0; t < NT; t++) cfg_write(t, rand_tree());

        for (int v = 0; v < 7; v++) begin
            for (int t = 0; t < NT; t++) begin
                plen_v[t] = int'(vecs[v].plen[t]);
                dly_v[t]  = int'(vecs[v].dly[t]);
            end
            eval(vecs[v].smp, vecs[v].th, vecs[v].exp_score, vecs[v].exp_anom, 1'b0, 0, 1'b0, '0);
        end

        // Result held under back-pressure while a new sample waits.
        plen_v = '{3, 4, 5, 6}; dly_v = '{0, 0, 0, 0};
        eval(8'h5A, 6'd20, 6'd18, 1'b1, 1'b0, 10, 1'b1, 8'h77);
        plen_v = '{1, 0, 15, 2};
        eval(8'h77, 6'd18, 6'd18, 1'b0, 1'b1, 0, 1'b0, '0);

        // Config write while evaluating is dropped.
        plen_v = '{1, 1, 1, 1}; dly_v = '{2, 0, 0, 0};
        d0 = drop_cnt;
        cfg_in_wait = 1;
        eval(8'h33, 6'd5, 6'd4, 1'b1, 1'b0, 0, 1'b0, '0);
        cfg_in_wait = 0;
        chk("cfg_drop_once", 64'(drop_cnt - d0), 64'd1);
        eval(8'h34, 6'd5, 6'd4, 1'b1, 1'b0, 0, 1'b0, '0);

        // Spurious engine completions in IDLE and LOAD.
        spurious = 1;
        eng_done = 1'b1; eng_plen = '1;
        repeat (2) @(negedge clk);
        eng_done = 1'b0;
        plen_v = '{2, 2, 2, 2}; dly_v = '{0, 0, 0, 0};
        eval(8'h55, 6'd9, 6'd8, 1'b1, 1'b0, 0, 1'b0, '0);
        spurious = 0;

        // Engine silent on tree 2.
        plen_v = '{1, 2, 3, 4}; dly_v = '{0, 0, 1000, 0};
`ifdef FOREST_SCHEDULER_WDOG_EN
        eval(8'h42, 6'd30, 6'd22, 1'b1, 1'b0, 0, 1'b0, '0);
        chk("wdog_sticky", 64'(wdog_err), 64'd1);
`else
        thresh = '0;
        start_sample(8'h42, 1'b0, 0, '0);
        run_engine(8'h42, 150, got, cyc);
        chk("wait_forever", 64'(got), 64'd0);
        chk("wait_busy", 64'({busy, wdog_err}), 64'b10);
`endif
        do_reset();
        chk("wdog_cleared", 64'(wdog_err), 64'd0);

        // Reset asserted during the LOAD of tree 1.
        for (int t = 0; t < NT; t++) cfg_write(t, rand_tree());
        start_sample(8'h66, 1'b0, 0, '0);
        chk("load0", 64'(eng_load), 64'd1);
        @(negedge clk);
        @(negedge clk);
        eng_done = 1'b1; eng_plen = 4'd5;
        @(negedge clk);
        eng_done = 1'b0;
        chk("load1", 64'(eng_load), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({eng_load, eng_start, res_valid, res_anomaly, cfg_drop, wdog_err, busy, s_ready}), 64'b00000001);
        chk("rst_mid_score", 64'(res_score), 64'd0);
        chk("rst_mid_data", 64'(eng_data), 64'd0);
        chk_tree("rst_mid_tree", eng_tree, '0);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < NT; t++) mbank[t] = '0;
        @(negedge clk);
        chk("post_rst", 64'({s_ready, busy}), 64'b10);
        for (int t = 0; t < NT; t++) cfg_write(t, rand_tree());
        plen_v = '{2, 3, 4, 5}; dly_v = '{0, 1, 0, 1};
        eval(8'h11, 6'd0, 6'd14, 1'b0, 1'b0, 0, 1'b0, '0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 30; n++) begin
            logic [DW-1:0] smp;
            logic [SW-1:0] th;
            bit            wc;
            int            widx;
            smp = DW'($urandom);
            th  = SW'($urandom_range(0, 63));
            for (int t = 0; t < NT; t++) begin
                plen_v[t] = $urandom_range(0, 15);
                dly_v[t]  = $urandom_range(0, 3);
            end
            sc = model_score();
            spurious = ($urandom_range(0, 3) == 0);
            wc = ($urandom_range(0, 1) == 1);
            widx = $urandom_range(0, NT - 1);
            thresh = th;
            start_sample(smp, wc, widx, rand_tree());
            eval(smp, th, SW'(sc), (sc < int'(th)), 1'b1, $urandom_range(0, 2), 1'b0, '0);
        end
        spurious = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
